// File: rtl/fetch_sequencer_if.sv
// Command/status bundle between decode/branch-resolve (master) and the fetch sequencer (slave).
// The master drives commands and immediates; the slave returns pc, stack status and flags.
interface fetch_sequencer_if #(
    parameter int ADDR_W      = 4,
    parameter int STACK_DEPTH = 16
);
    localparam int CNT_W = $clog2(STACK_DEPTH + 1);

    logic              stall;
    logic              advance;
    logic              jump;
    logic              beq_set;
    logic              bne_set;
    logic              call;
    logic              ret;
    logic [ADDR_W-1:0] imm_address_jump;
    logic [ADDR_W-1:0] imm_address_branch;
    logic              clear_err;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] return_address;
    logic [CNT_W-1:0]  stack_count;
    logic              redirect;
    logic              stack_overflow;
    logic              stack_underflow;

    modport master (
        output stall, advance, jump, beq_set, bne_set, call, ret,
               imm_address_jump, imm_address_branch, clear_err,
        input  pc, return_address, stack_count, redirect,
               stack_overflow, stack_underflow
    );

    modport slave (
        input  stall, advance, jump, beq_set, bne_set, call, ret,
               imm_address_jump, imm_address_branch, clear_err,
        output pc, return_address, stack_count, redirect,
               stack_overflow, stack_underflow
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer: sequential/jump/branch/call/return fetch address generation
// with a bounded return stack, sticky overflow/underflow flags and a redirect pulse.
module fetch_sequencer #(
    parameter int              ADDR_W      = 4,
    parameter int              STACK_DEPTH = 16,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [ADDR_W-1:0] TGT_OFFSET = ADDR_W'(1)
) (
    input  logic                clk,
    input  logic                reset,
    fetch_sequencer_if.slave    bus
);
    localparam int CNT_W = $clog2(STACK_DEPTH + 1);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  stack_count_q, stack_count_d;
    logic              redirect_q, redirect_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              push;
    logic [ADDR_W-1:0] top_entry;
    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] pc_plus_one;

    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
    logic [ADDR_W-1:0] stack_d [STACK_DEPTH];

    assign jump_target   = bus.imm_address_jump + TGT_OFFSET;
    assign branch_target = bus.imm_address_branch + TGT_OFFSET;
    assign pc_plus_one   = pc_q + ADDR_W'(1);

    // Stack storage is never reset; only the count defines which entries are live.
    generate
        for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_stack
            assign stack_d[gi] = (push && stack_count_q == CNT_W'(gi)) ? pc_plus_one : stack_q[gi];
            always_ff @(posedge clk) begin
                stack_q[gi] <= stack_d[gi];
            end
        end
    endgenerate

    always_comb begin
        top_entry = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (stack_count_q == CNT_W'(i + 1)) top_entry = stack_q[i];
        end
    end

    // Command priority: call > ret > jump > branch > advance; lower ones are dropped.
    always_comb begin
        pc_d          = pc_q;
        stack_count_d = stack_count_q;
        redirect_d    = 1'b0;
        overflow_d    = overflow_q;
        underflow_d   = underflow_q;
        push          = 1'b0;
        if (!bus.stall) begin
            if (bus.clear_err) begin
                overflow_d  = 1'b0;
                underflow_d = 1'b0;
            end
            if (bus.call) begin
                if (stack_count_q != CNT_W'(STACK_DEPTH)) begin
                    push          = 1'b1;
                    stack_count_d = stack_count_q + CNT_W'(1);
                    pc_d          = jump_target;
                    redirect_d    = 1'b1;
                end else begin
                    overflow_d = 1'b1;
                end
            end else if (bus.ret) begin
                if (stack_count_q != '0) begin
                    pc_d          = top_entry;
                    stack_count_d = stack_count_q - CNT_W'(1);
                    redirect_d    = 1'b1;
                end else begin
                    underflow_d = 1'b1;
                end
            end else if (bus.jump) begin
                pc_d       = jump_target;
                redirect_d = 1'b1;
            end else if (bus.beq_set || bus.bne_set) begin
                pc_d       = branch_target;
                redirect_d = 1'b1;
            end else if (bus.advance) begin
                pc_d = pc_plus_one;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            stack_count_q <= '0;
            redirect_q    <= 1'b0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            stack_count_q <= stack_count_d;
            redirect_q    <= redirect_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
        end
    end

    assign bus.pc              = pc_q;
    assign bus.return_address  = top_entry;
    assign bus.stack_count     = stack_count_q;
    assign bus.redirect        = redirect_q;
    assign bus.stack_overflow  = overflow_q;
    assign bus.stack_underflow = underflow_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer (ADDR_W=4, STACK_DEPTH=2, TGT_OFFSET=1).
module tb_fetch_sequencer;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    fetch_sequencer_if #(.ADDR_W(ADDR_W), .STACK_DEPTH(DEPTH)) bus ();

    fetch_sequencer #(
        .ADDR_W(ADDR_W), .STACK_DEPTH(DEPTH),
        .RESET_PC(4'd0), .TGT_OFFSET(4'd1)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic idle_inputs();
        bus.stall = 0; bus.advance = 0; bus.jump = 0; bus.beq_set = 0; bus.bne_set = 0;
        bus.call = 0; bus.ret = 0; bus.clear_err = 0;
        bus.imm_address_jump = '0; bus.imm_address_branch = '0;
    endtask

    // Apply one command for one edge, sample 1 time unit after the edge.
    task automatic cmd(input bit st, input bit cl, input bit rt, input bit jp, input bit bq,
                       input bit bn, input bit adv, input bit ce,
                       input logic [ADDR_W-1:0] ij, input logic [ADDR_W-1:0] ib);
        bus.stall = st; bus.call = cl; bus.ret = rt; bus.jump = jp; bus.beq_set = bq;
        bus.bne_set = bn; bus.advance = adv; bus.clear_err = ce;
        bus.imm_address_jump = ij; bus.imm_address_branch = ib;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic check_state(input string tag, input int pc, input int cnt, input int ra,
                               input int rd);
        check({tag, ".pc"}, bus.pc, pc);
        check({tag, ".cnt"}, bus.stack_count, cnt);
        check({tag, ".ra"}, bus.return_address, ra);
        check({tag, ".redir"}, bus.redirect, rd);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle_inputs();
        reset = 1'b1;
        #12;
        check_state("reset", 0, 0, 0, 0);
        check("reset.ovf", bus.stack_overflow, 0);
        check("reset.unf", bus.stack_underflow, 0);
        @(negedge clk);
        reset = 1'b0;

        // 17 advances wrap through 15 back to 1
        for (int k = 1; k <= 17; k++) begin
            cmd(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
            check($sformatf("adv%0d.pc", k), bus.pc, k % 16);
            check($sformatf("adv%0d.redir", k), bus.redirect, 0);
        end

        cmd(0, 0, 0, 1, 0, 0, 0, 0, 4'd2, 0);
        check_state("jump2", 3, 0, 0, 1);
        cmd(0, 1, 0, 0, 0, 0, 0, 0, 4'd9, 0);
        check_state("call9", 10, 1, 4, 1);
        cmd(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_state("idle", 10, 1, 4, 0);
        cmd(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        check_state("ret", 4, 0, 0, 1);

        // Fill the two-entry stack, then overflow
        cmd(0, 1, 0, 0, 0, 0, 0, 0, 4'd4, 0);
        check_state("callA", 5, 1, 5, 1);
        cmd(0, 1, 0, 0, 0, 0, 0, 0, 4'd7, 0);
        check_state("callB", 8, 2, 6, 1);
        cmd(0, 1, 0, 0, 0, 0, 0, 0, 4'd12, 0);
        check_state("callC", 8, 2, 6, 0);
        check("callC.ovf", bus.stack_overflow, 1);
        cmd(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        check("clr.ovf", bus.stack_overflow, 0);

        cmd(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        check_state("retB", 6, 1, 5, 1);
        cmd(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        check_state("retA", 5, 0, 0, 1);
        cmd(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        check_state("retE", 5, 0, 0, 0);
        check("retE.unf", bus.stack_underflow, 1);
        cmd(0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
        check("retclr.unf", bus.stack_underflow, 1);
        check("retclr.pc", bus.pc, 5);

        // Stall freezes everything, including clear_err
        cmd(1, 1, 0, 1, 0, 0, 1, 1, 4'd3, 0);
        check_state("stall", 5, 0, 0, 0);
        check("stall.unf", bus.stack_underflow, 1);
        cmd(0, 1, 0, 1, 0, 0, 1, 0, 4'd3, 0);
        check_state("unstall", 4, 1, 6, 1);
        cmd(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        check("clr.unf", bus.stack_underflow, 0);

        // Branches and wrapping targets
        cmd(0, 0, 0, 0, 1, 0, 0, 0, 0, 4'd14);
        check_state("beq", 15, 1, 6, 1);
        cmd(0, 0, 0, 0, 0, 1, 0, 0, 0, 4'd15);
        check_state("bne", 0, 1, 6, 1);
        cmd(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        check_state("adv", 1, 1, 6, 0);
        cmd(0, 0, 0, 1, 0, 0, 0, 0, 4'd15, 0);
        check_state("jwrap", 0, 1, 6, 1);

        // Async reset between edges during a call sequence
        cmd(0, 1, 0, 0, 0, 0, 0, 0, 4'd9, 0);
        check_state("callR", 10, 2, 1, 1);
        bus.call = 1; bus.imm_address_jump = 4'd5;
        #2;
        reset = 1'b1;
        #1;
        check_state("areset", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check_state("areset_hold", 0, 0, 0, 0);
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
        cmd(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        check_state("postreset", 1, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
